// File: rtl/lift_row_seq.sv
// Row sequencer for a lifting transform: it reads the L/S/R operands of each
// step from the row buffer, drives the lift_step datapath, and writes the result back.
module lift_row_seq #(
  parameter int         ROW_LEN    = 16,
  parameter int         AW         = 4,
  parameter logic [2:0] FLAGS_PRED = 3'd7,
  parameter logic [2:0] FLAGS_UPD  = 3'd5,
  parameter int         TIMEOUT    = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [AW-1:0]     mem_addr_o,
  output logic              mem_rd_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              mem_wr_o,
  output logic [7:0]        mem_wdata_o,
  output logic [2:0]        flags_o,
  output logic [7:0]        left_o,
  output logic [7:0]        sam_o,
  output logic [7:0]        right_o,
  output logic              update_o,
  input  logic signed [8:0] res_i,
  input  logic              done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, RD_L, RD_S, RD_R, CAP, ISSUE, WAIT_RES, WRITE, NEXT
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d, idx_nx;
  logic            upd_ph_q, upd_ph_d, upd_ph_nx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rd_q, rd_d, wr_q, wr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [2:0]      flags_q, flags_d;
  logic [7:0]      left_q, left_d, sam_q, sam_d, right_q, right_d;
  logic            upd_q, upd_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic unused_res_msb;
  assign unused_res_msb = res_i[8];

  // Symmetric extension at both row edges.
  function automatic logic [AW-1:0] l_of(input logic [AW-1:0] i);
    return (i == '0) ? AW'(1) : i - AW'(1);
  endfunction

  function automatic logic [AW-1:0] r_of(input logic [AW-1:0] i);
    return (i == AW'(ROW_LEN - 1)) ? AW'(ROW_LEN - 2) : i + AW'(1);
  endfunction

  always_comb begin
    idx_nx    = idx_q + AW'(2);
    upd_ph_nx = upd_ph_q;
    if (!upd_ph_q && idx_q == AW'(ROW_LEN - 1)) begin
      idx_nx    = '0;
      upd_ph_nx = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    upd_ph_d = upd_ph_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    flags_d  = flags_q;
    left_d   = left_q;
    sam_d    = sam_q;
    right_d  = right_q;
    busy_d   = busy_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    upd_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d  = RD_L;
        busy_d   = 1'b1;
        idx_d    = AW'(1);
        upd_ph_d = 1'b0;
        rd_d     = 1'b1;
        addr_d   = l_of(AW'(1));
      end
      RD_L: begin
        state_d = RD_S;
        rd_d    = 1'b1;
        addr_d  = idx_q;
      end
      RD_S: begin
        state_d = RD_R;
        left_d  = mem_rdata_i;
        rd_d    = 1'b1;
        addr_d  = r_of(idx_q);
      end
      RD_R: begin
        state_d = CAP;
        sam_d   = mem_rdata_i;
      end
      CAP: begin
        state_d = ISSUE;
        right_d = mem_rdata_i;
        upd_d   = 1'b1;
        flags_d = upd_ph_q ? FLAGS_UPD : FLAGS_PRED;
      end
      ISSUE: begin
        state_d = WAIT_RES;
        cnt_d   = '0;
      end
      // cnt_q is 0 on the first wait cycle, so err_o lands TIMEOUT cycles after ISSUE.
      WAIT_RES: begin
        if (done_i) begin
          state_d = WRITE;
          wr_d    = 1'b1;
          addr_d  = idx_q;
          wdata_d = res_i[7:0];
        end else if (cnt_q == CW'(TIMEOUT - 2)) begin
          state_d = IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WRITE: state_d = NEXT;
      NEXT: begin
        if (upd_ph_q && idx_q == AW'(ROW_LEN - 2)) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          idx_d    = AW'(1);
          upd_ph_d = 1'b0;
        end else begin
          state_d  = RD_L;
          idx_d    = idx_nx;
          upd_ph_d = upd_ph_nx;
          rd_d     = 1'b1;
          addr_d   = l_of(idx_nx);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= AW'(1);
      upd_ph_q <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      flags_q  <= '0;
      left_q   <= '0;
      sam_q    <= '0;
      right_q  <= '0;
      upd_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      upd_ph_q <= upd_ph_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      flags_q  <= flags_d;
      left_q   <= left_d;
      sam_q    <= sam_d;
      right_q  <= right_d;
      upd_q    <= upd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_rd_o    = rd_q;
  assign mem_wr_o    = wr_q;
  assign mem_wdata_o = wdata_q;
  assign flags_o     = flags_q;
  assign left_o      = left_q;
  assign sam_o       = sam_q;
  assign right_o     = right_q;
  assign update_o    = upd_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_lift_row_seq.sv
// Bench for lift_row_seq: row-buffer memory, lift_step stub and a step-list model
// built from the lifting rules, checked against the DUT every cycle.
module tb_lift_row_seq;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int TO = 64;

  logic              clk = 0, rst_i = 1, start_i = 0;
  logic [AW-1:0]     mem_addr_o;
  logic              mem_rd_o, mem_wr_o, update_o, busy_o, done_o, err_o;
  logic [7:0]        mem_rdata_i = 0, mem_wdata_o, left_o, sam_o, right_o;
  logic [2:0]        flags_o;
  logic signed [8:0] res_i = 0;
  logic              done_i = 0;

  lift_row_seq #(.ROW_LEN(N), .AW(AW), .FLAGS_PRED(3'd7), .FLAGS_UPD(3'd5), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .mem_rdata_i(mem_rdata_i),
    .mem_wr_o(mem_wr_o), .mem_wdata_o(mem_wdata_o),
    .flags_o(flags_o), .left_o(left_o), .sam_o(sam_o), .right_o(right_o),
    .update_o(update_o), .res_i(res_i), .done_i(done_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int nvec = 0, nmis = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Row buffer and lift_step stub
  logic [7:0] mem [N];
  logic [7:0] init_mem [N];
  logic [7:0] rd_snap = 0;
  int stub_mode = 0, stub_dly = 1, stub_cnt = -1;
  bit stub_spurious = 0;
  logic signed [8:0] stub_pend = 0;

  function automatic logic signed [8:0] stub_res(input int mode, input logic [7:0] l, s, r);
    int v;
    case (mode)
      0: v = int'(s) + 1;
      1: v = 103;
      2: v = -3;
      default: v = int'(l) + int'(r) - int'(s);
    endcase
    return 9'(v);
  endfunction

  initial forever begin
    @(negedge clk);
    mem_rdata_i = rd_snap;
    if (mem_rd_o) rd_snap = mem[mem_addr_o];
    if (mem_wr_o) mem[mem_addr_o] = mem_wdata_o;
  end

  initial forever begin
    @(negedge clk);
    done_i = 0;
    if (rst_i) stub_cnt = -1;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin done_i = 1; res_i = stub_pend; stub_cnt = -1; end
    end
    if (update_o && !rst_i) begin
      stub_pend = stub_res(stub_mode, left_o, sam_o, right_o);
      stub_cnt  = stub_dly;
      if (stub_spurious) begin done_i = 1; res_i = 9'sh0AA; end
    end
  end

  // Model: step list of the whole row from the lifting rules
  int          rd_q[$];
  logic [26:0] iss_q[$], iss_log[$];
  logic [15:0] wr_q[$], wr_log[$];
  bit          err_exp = 0;

  task automatic build_model(input int mode, input int n_steps);
    logic [7:0] m [N];
    logic signed [8:0] res;
    int l, r, steps;
    for (int k = 0; k < N; k++) m[k] = init_mem[k];
    rd_q.delete(); iss_q.delete(); wr_q.delete();
    steps = 0;
    for (int ph = 0; ph < 2; ph++)
      for (int i = (ph == 0) ? 1 : 0; i < N; i += 2) begin
        if (steps < n_steps) begin
          l = (i == 0) ? 1 : i - 1;
          r = (i == N - 1) ? N - 2 : i + 1;
          res = stub_res(mode, m[l], m[i], m[r]);
          rd_q.push_back(l); rd_q.push_back(i); rd_q.push_back(r);
          iss_q.push_back({(ph == 1) ? 3'd5 : 3'd7, m[l], m[i], m[r]});
          wr_q.push_back({8'(i), res[7:0]});
          m[i] = res[7:0];
        end
        steps++;
      end
  endtask

  // Compare process
  int cyc = 0, first_rd_cyc = 0, issue_cyc = 0, done_seen = 0, err_seen = 0;
  logic [26:0] cur_iss = 0;
  bit prev_upd = 0, prev_done = 0, prev_err = 0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_i) begin
      if (mem_rd_o && mem_wr_o) chk("rd_wr_excl", 1, 0);
      if (mem_rd_o) begin
        if (rd_q.size() == 0) chk("rd_unexpected", mem_addr_o, 64'hFFFF);
        else begin
          chk("rd_addr", 64'(mem_addr_o), 64'(rd_q.pop_front()));
          if (rd_q.size() % 3 == 2) first_rd_cyc = cyc;
        end
      end
      if (update_o) begin
        chk("upd_pulse", prev_upd, 0);
        chk("rd_to_issue", cyc - first_rd_cyc, 4);
        iss_log.push_back({flags_o, left_o, sam_o, right_o});
        if (iss_q.size() == 0) chk("issue_unexpected", 1, 0);
        else begin
          cur_iss = iss_q.pop_front();
          chk("issue_ops", {flags_o, left_o, sam_o, right_o}, cur_iss);
        end
        issue_cyc = cyc;
      end
      if (mem_wr_o) begin
        wr_log.push_back({6'd0, mem_addr_o, mem_wdata_o});
        if (wr_q.size() == 0) chk("wr_unexpected", {mem_addr_o, mem_wdata_o}, 64'hFFFF);
        else chk("wr_addr_data", {6'd0, mem_addr_o, mem_wdata_o}, wr_q.pop_front());
        chk("ops_stable", {flags_o, left_o, sam_o, right_o}, cur_iss);
        chk("issue_to_wr", cyc - issue_cyc, stub_dly + 1);
      end
      if (done_o) begin
        done_seen++;
        chk("done_pulse", prev_done, 0);
        chk("done_all_steps", wr_q.size() + iss_q.size() + rd_q.size(), 0);
      end
      if (err_o) begin
        err_seen++;
        chk("err_pulse", prev_err, 0);
        chk("err_expected", err_exp, 1);
        chk("err_dist", cyc - issue_cyc, TO);
        chk("err_busy", busy_o, 0);
      end
    end
    prev_upd = update_o; prev_done = done_o; prev_err = err_o;
  end

  task automatic load_row(input logic [7:0] a, b, c, d);
    init_mem[0] = a; init_mem[1] = b; init_mem[2] = c; init_mem[3] = d;
    for (int k = 0; k < N; k++) mem[k] = init_mem[k];
    iss_log.delete(); wr_log.delete();
  endtask

  task automatic run_row(input bit dup);
    int busy_bad;
    bit ok;
    @(negedge clk); start_i = 1;
    @(negedge clk); start_i = 0;
    ok = 0; busy_bad = 0;
    for (int k = 0; k < 3000; k++) begin
      if (done_o || err_o) begin ok = 1; break; end
      if (busy_o !== 1'b1) busy_bad++;
      start_i = dup && (k == 6 || k == 12);
      @(negedge clk);
    end
    start_i = 0;
    chk("row_end_reached", ok, 1);
    chk("busy_span", busy_bad, 0);
    repeat (3) @(negedge clk);
    chk("idle_after_row", busy_o, 0);
  endtask

  function automatic logic [63:0] mem_word();
    return {32'd0, mem[0], mem[1], mem[2], mem[3]};
  endfunction

  int d0, e0, nupd;
  initial begin
    #1;
    chk("reset_outputs", {mem_addr_o, mem_rd_o, mem_wdata_o, mem_wr_o, flags_o, left_o, sam_o,
        right_o, update_o, busy_o, done_o, err_o}, 0);
    repeat (2) @(negedge clk);
    rst_i = 0;

    // Constant result 103, reply two cycles after update_o
    load_row(68, 218, 163, 160);
    stub_mode = 1; stub_dly = 2; build_model(1, 4);
    d0 = done_seen;
    run_row(0);
    chk("s1_first_issue", iss_log[0], {3'd7, 8'd68, 8'd218, 8'd163});
    chk("s1_first_write", wr_log[0], {8'd1, 8'd103});
    chk("s1_i3_right_mirror", iss_log[1][7:0], 163);
    chk("s1_i0_left_pred", iss_log[2][23:16], 103);
    chk("s1_upd_flags", iss_log[2][26:24], 5);
    chk("s1_mem", mem_word(), {32'd0, 8'd103, 8'd103, 8'd103, 8'd103});
    chk("s1_done_cnt", done_seen - d0, 1);

    // sam+1, single-cycle wait: write order 1,3,0,2
    load_row(68, 218, 163, 160);
    stub_mode = 0; stub_dly = 1; build_model(0, 4);
    d0 = done_seen;
    run_row(0);
    chk("s2_wr_order", {wr_log[0][15:8], wr_log[1][15:8], wr_log[2][15:8], wr_log[3][15:8]},
        {8'd1, 8'd3, 8'd0, 8'd2});
    chk("s2_nwrites", wr_log.size(), 4);
    chk("s2_mem", mem_word(), {32'd0, 8'd69, 8'd219, 8'd164, 8'd161});
    chk("s2_done_cnt", done_seen - d0, 1);

    // No reply: timeout, no write
    load_row(10, 20, 30, 40);
    stub_mode = 0; stub_dly = 0; build_model(0, 1); wr_q.delete();
    err_exp = 1; e0 = err_seen; d0 = done_seen;
    run_row(0);
    err_exp = 0;
    chk("to_err_cnt", err_seen - e0, 1);
    chk("to_no_done", done_seen - d0, 0);
    chk("to_no_write", wr_log.size(), 0);
    chk("to_mem", mem_word(), {32'd0, 8'd10, 8'd20, 8'd30, 8'd40});
    chk("to_queues_empty", iss_q.size() + rd_q.size(), 0);

    // Reset during the wait of step i=3, then a fresh row
    load_row(68, 218, 163, 160);
    stub_mode = 0; stub_dly = 5; build_model(0, 4);
    d0 = done_seen;
    @(negedge clk); start_i = 1;
    @(negedge clk); start_i = 0;
    nupd = 0;
    for (int k = 0; k < 200 && nupd < 2; k++) begin
      @(negedge clk);
      if (update_o) nupd++;
    end
    chk("rst_reached_i3", nupd, 2);
    repeat (2) @(negedge clk);
    #2 rst_i = 1;
    rd_q.delete(); iss_q.delete(); wr_q.delete();
    #1;
    chk("rst_async_outputs", {mem_addr_o, mem_rd_o, mem_wdata_o, mem_wr_o, flags_o, left_o, sam_o,
        right_o, update_o, busy_o, done_o, err_o}, 0);
    repeat (3) @(negedge clk);
    rst_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_no_done", done_seen - d0, 0);
    chk("rst_one_write_only", wr_log.size(), 1);
    load_row(68, 218, 163, 160);
    stub_dly = 3; build_model(0, 4);
    run_row(0);
    chk("rst_fresh_mem", mem_word(), {32'd0, 8'd69, 8'd219, 8'd164, 8'd161});
    chk("rst_fresh_done", done_seen - d0, 1);

    // Negative result, start while busy, stray done_i with update_o
    load_row(1, 2, 3, 4);
    stub_mode = 2; stub_dly = 2; stub_spurious = 1; build_model(2, 4);
    d0 = done_seen;
    run_row(1);
    stub_spurious = 0;
    chk("neg_wdata", wr_log[0][7:0], 8'hFD);
    chk("neg_mem", mem_word(), {32'd0, 8'hFD, 8'hFD, 8'hFD, 8'hFD});
    chk("dup_start_done_cnt", done_seen - d0, 1);

    // Mixed-operand result on a different row
    load_row(200, 7, 90, 255);
    stub_mode = 3; stub_dly = 4; build_model(3, 4);
    run_row(0);
    chk("mix_nwrites", wr_log.size(), 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
